// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core sequencer and its wait timer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    IWAIT = 3'd2,
    EXEC  = 3'd3,
    MEM   = 3'd4,
    WB    = 3'd5
  } seq_state_t;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam int unsigned DEFAULT_WAIT_LIMIT = 16;

  // States that wait on an external memory response and are bounded by the timer.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == FETCH) || (s == IWAIT) || (s == MEM);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Down-counting response timer: reloaded on entry to a wait state, expires on
// the LIMIT-th consecutive enabled cycle.
module seq_wait_timer
  import core_seq_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic clk,
  input  logic arst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The first cycle in the state sees LIMIT-1, so terminal count lands on cycle LIMIT.
  assign expire = enable && (count == '0);

endmodule

// File: rtl/core_sequencer.sv
// Fetch/execute control sequencer gating datapath strobes around memory handshakes.
// Optional CORE_SEQ_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | imem_req held until imem_gnt
//   IWAIT | waiting for imem_rvalid
//   EXEC  | one decode cycle, branch to MEM/WB/IDLE
//   MEM   | dmem_req held until dmem_ack
//   WB    | single cycle of pc/reg write strobes
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic                  halt_req,
  output logic                  imem_req,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_q,
  input  logic                  ctl_pc_write,
  input  logic                  ctl_regwrite,
  input  logic                  ctl_memread,
  input  logic                  ctl_memwrite,
  output logic                  pc_write_en,
  output logic                  reg_write_en,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            state_o
`ifdef CORE_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]           retired_cnt
`endif
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic       latch_instr;
  logic       timeout;
  logic       halt_pending;
  logic       tmr_load;
  logic       tmr_expire;

  always_comb begin
    state_nxt   = state;
    latch_instr = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        // A response arriving with the grant skips IWAIT entirely.
        if (imem_gnt && imem_rvalid) begin
          latch_instr = 1'b1;
          state_nxt   = EXEC;
        end else if (imem_gnt) begin
          state_nxt = IWAIT;
        end else if (tmr_expire) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      IWAIT: begin
        if (imem_rvalid) begin
          latch_instr = 1'b1;
          state_nxt   = EXEC;
        end else if (tmr_expire) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        if (instr_q == DATA_WIDTH'(EBREAK_INSN)) state_nxt = IDLE;
        else if (ctl_memread || ctl_memwrite)    state_nxt = MEM;
        else                                     state_nxt = WB;
      end
      MEM: begin
        if (dmem_ack) begin
          state_nxt = WB;
        end else if (tmr_expire) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WB: begin
        state_nxt = (halt_pending || halt_req) ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tmr_load = (state_nxt != state) && is_wait_state(state_nxt);

  seq_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk    (clk),
    .arst_n (arst_n),
    .load   (tmr_load),
    .enable (is_wait_state(state)),
    .expire (tmr_expire)
  );

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= IDLE;
      instr_q      <= '0;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      pc_write_en  <= 1'b0;
      reg_write_en <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      if (latch_instr) instr_q <= imem_rdata;
      imem_req     <= (state_nxt == FETCH);
      dmem_req     <= (state_nxt == MEM);
      dmem_we      <= (state_nxt == MEM) && ctl_memwrite;
      pc_write_en  <= (state_nxt == WB) && ctl_pc_write;
      reg_write_en <= (state_nxt == WB) && ctl_regwrite;
      busy         <= (state_nxt != IDLE);
      if ((state == IDLE) && start) err <= 1'b0;
      else if (timeout)             err <= 1'b1;
      if (state_nxt == IDLE)                halt_pending <= 1'b0;
      else if ((state != IDLE) && halt_req) halt_pending <= 1'b1;
    end
  end

  assign state_o = state;

`ifdef CORE_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!arst_n)                     retired_cnt <= '0;
    else if ((state == IDLE) && start) retired_cnt <= '0;
    else if (state == WB)            retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed vector table, randomized trials against a
// duration-based reference model, and a reset-during-MEM sequence.
module tb_core_sequencer;
  import core_seq_pkg::*;

  localparam int DW  = 32;
  localparam int LIM = 16;
  localparam logic [31:0] ADD_I = 32'h0020_81b3;
  localparam logic [31:0] LW_I  = 32'h0000_a103;
  localparam logic [31:0] SW_I  = 32'h0020_a023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n, start, halt_req, imem_gnt, imem_rvalid, dmem_ack;
  logic          ctl_pc_write, ctl_regwrite, ctl_memread, ctl_memwrite;
  logic [DW-1:0] imem_rdata, instr_q;
  logic          imem_req, pc_write_en, reg_write_en, dmem_req, dmem_we, busy, err;
  logic [2:0]    state_o;
`ifdef CORE_SEQ_RETIRE_CNT_EN
  logic [31:0]   retired_cnt;
`endif

  core_sequencer #(.DATA_WIDTH(DW), .WAIT_LIMIT(LIM)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_q(instr_q),
    .ctl_pc_write(ctl_pc_write), .ctl_regwrite(ctl_regwrite),
    .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite),
    .pc_write_en(pc_write_en), .reg_write_en(reg_write_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .busy(busy), .err(err), .state_o(state_o)
`ifdef CORE_SEQ_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  typedef struct {
    int          g, r, a;          // gnt delay, rvalid delay after gnt, ack delay
    bit          mr, mw, rw, pcw, hp;
    logic [31:0] insn;
    int          e_busy, e_imem, e_dmem, e_we;
    bit          e_reg, e_pc, e_err, e_lat;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_instr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int g, r, a, input bit mr, mw, rw, pcw, hp,
                              input logic [31:0] insn, input int eb, ei, ed, ew,
                              input bit er, ep, ee, el);
    vec_t v;
    v.g = g; v.r = r; v.a = a; v.mr = mr; v.mw = mw; v.rw = rw; v.pcw = pcw; v.hp = hp;
    v.insn = insn; v.e_busy = eb; v.e_imem = ei; v.e_dmem = ed; v.e_we = ew;
    v.e_reg = er; v.e_pc = ep; v.e_err = ee; v.e_lat = el;
    return v;
  endfunction

  // Reference: cycles spent in each phase of one instruction, from the handshake delays.
  function automatic vec_t model(input vec_t v);
    vec_t m;
    int f, iw, ex, mc;
    bit to, wb;
    m = v; to = 0; f = 0; iw = 0; ex = 0; mc = 0; wb = 0;
    if (v.g + 1 > LIM) begin
      f = LIM; to = 1;
    end else begin
      f = v.g + 1;
      if (v.r > LIM) begin iw = LIM; to = 1; end
      else iw = v.r;
    end
    m.e_lat = !to;
    if (!to) begin
      ex = 1;
      if (v.insn != EBREAK_INSN && (v.mr || v.mw)) begin
        if (v.a + 1 > LIM) begin mc = LIM; to = 1; end
        else mc = v.a + 1;
      end
      wb = !to && (v.insn != EBREAK_INSN);
    end
    m.e_busy = f + iw + ex + mc + int'(wb);
    m.e_imem = f;
    m.e_dmem = mc;
    m.e_we   = v.mw ? mc : 0;
    m.e_reg  = wb && v.rw;
    m.e_pc   = wb && v.pcw;
    m.e_err  = to;
    return m;
  endfunction

  task automatic clear_inputs();
    start = 0; halt_req = 0; imem_gnt = 0; imem_rvalid = 0; dmem_ack = 0;
    ctl_pc_write = 0; ctl_regwrite = 0; ctl_memread = 0; ctl_memwrite = 0;
  endtask

  // Called at a negedge with the DUT idle; runs one instruction to completion.
  task automatic run_trial(input vec_t v, input string tag);
    int fcnt, sg, dcnt, bn, imn, dmn, wen, rgn, pcn, rgpos, pcpos;
    bit done, wb;
    fcnt = 0; sg = -1; dcnt = 0; bn = 0; imn = 0; dmn = 0; wen = 0;
    rgn = 0; pcn = 0; rgpos = -1; pcpos = -1; done = 0;
    ctl_memread = v.mr; ctl_memwrite = v.mw; ctl_regwrite = v.rw; ctl_pc_write = v.pcw;
    imem_rdata = v.insn;
    halt_req = v.hp ? 1'b0 : 1'b1;
    start = 1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
      if (reg_write_en) begin rgn++; rgpos = bn; end
      if (pc_write_en)  begin pcn++; pcpos = bn; end
      if (imem_req) begin imn++; fcnt++; end
      if (dmem_req) begin dmn++; dcnt++; end
      if (dmem_we) wen++;
      bn++;
      imem_gnt = imem_req && (fcnt == v.g + 1);
      if (imem_gnt) sg = 0;
      else if (sg >= 0) sg++;
      imem_rvalid = (imem_gnt && v.r == 0) || (!imem_gnt && v.r > 0 && sg == v.r);
      dmem_ack = dmem_req && (dcnt == v.a + 1);
      halt_req = v.hp ? (dmem_req && dcnt == 1) : 1'b1;
      start = ($urandom_range(0, 3) == 0);
    end
    clear_inputs();
    check({tag, "_finished"}, 64'(done), 64'd1);
    check({tag, "_busy_cycles"}, bn, v.e_busy);
    check({tag, "_imem_req_cycles"}, imn, v.e_imem);
    check({tag, "_dmem_req_cycles"}, dmn, v.e_dmem);
    check({tag, "_dmem_we_cycles"}, wen, v.e_we);
    check({tag, "_reg_write_pulses"}, rgn, 64'(v.e_reg));
    check({tag, "_pc_write_pulses"}, pcn, 64'(v.e_pc));
    if (v.e_reg) check({tag, "_reg_write_cycle"}, rgpos, v.e_busy - 1);
    if (v.e_pc)  check({tag, "_pc_write_cycle"}, pcpos, v.e_busy - 1);
    check({tag, "_err"}, 64'(err), 64'(v.e_err));
    check({tag, "_state_idle"}, state_o, IDLE);
    check({tag, "_idle_strobes"}, {imem_req, dmem_req, dmem_we, pc_write_en, reg_write_en}, 0);
    if (v.e_lat) last_instr = v.insn;
    check({tag, "_instr_q"}, instr_q, last_instr);
    wb = !v.e_err && (v.insn != EBREAK_INSN);
`ifdef CORE_SEQ_RETIRE_CNT_EN
    check({tag, "_retired_cnt"}, retired_cnt, 64'(wb));
`else
    if (wb) check({tag, "_wb_strobe_seen"}, 64'(rgn + pcn > 0 || !(v.rw || v.pcw)), 64'd1);
`endif
    if (!done) begin
      arst_n = 0;
      repeat (2) @(negedge clk);
      arst_n = 1;
      last_instr = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    bit   wb_seen, mem_seen;

    clear_inputs();
    imem_rdata = '0;
    arst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", state_o, IDLE);
    check("reset_instr_q", instr_q, 0);
    check("reset_busy_err", {busy, err}, 0);
    check("reset_strobes", {imem_req, dmem_req, dmem_we, pc_write_en, reg_write_en}, 0);
    arst_n = 1;

    //            g   r   a  mr mw rw pc hp insn          busy imem dmem we  reg pc err lat
    tbl.push_back(mk(0,  0,  0, 0, 0, 1, 1, 0, ADD_I,        3,  1,   0,  0, 1,  1, 0,  1));
    tbl.push_back(mk(0,  1,  0, 0, 0, 0, 1, 0, ADD_I,        4,  1,   0,  0, 0,  1, 0,  1));
    tbl.push_back(mk(0,  0,  2, 1, 0, 1, 1, 1, LW_I,         6,  1,   3,  0, 1,  1, 0,  1));
    tbl.push_back(mk(1,  2,  0, 0, 1, 0, 1, 0, SW_I,         7,  2,   1,  1, 0,  1, 0,  1));
    tbl.push_back(mk(0,  0,  0, 0, 0, 1, 1, 0, EBREAK_INSN,  2,  1,   0,  0, 0,  0, 0,  1));
    tbl.push_back(mk(0, 20,  0, 0, 0, 1, 1, 0, LW_I,        17,  1,   0,  0, 0,  0, 1,  0));
    tbl.push_back(mk(20, 0,  0, 0, 0, 1, 1, 0, SW_I,        16, 16,   0,  0, 0,  0, 1,  0));
    tbl.push_back(mk(0,  0, 20, 1, 0, 1, 1, 0, LW_I,        18,  1,  16,  0, 0,  0, 1,  1));
    tbl.push_back(mk(0, 16,  0, 0, 0, 1, 0, 0, ADD_I,       19,  1,   0,  0, 1,  0, 0,  1));
    tbl.push_back(mk(15, 0,  0, 0, 0, 0, 1, 0, SW_I,        18, 16,   0,  0, 0,  1, 0,  1));
    tbl.push_back(mk(0,  0, 15, 0, 1, 0, 1, 0, SW_I,        19,  1,  16, 16, 0,  1, 0,  1));
    tbl.push_back(mk(0, 17,  0, 0, 0, 1, 1, 0, ADD_I,       17,  1,   0,  0, 0,  0, 1,  0));

    for (int i = 0; i < tbl.size(); i++) run_trial(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v = mk(($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0,
             ($urandom_range(0, 5) == 0) ? EBREAK_INSN : $urandom(),
             0, 0, 0, 0, 0, 0, 0, 0);
      run_trial(model(v), $sformatf("rnd%0d", i));
    end

    // Reset while the second load of a run sits in MEM.
    ctl_memread = 1; ctl_pc_write = 1; imem_rdata = LW_I;
    wb_seen = 0; mem_seen = 0;
    start = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 0;
      if (pc_write_en) wb_seen = 1;
      if (dmem_req && wb_seen) begin mem_seen = 1; break; end
      imem_gnt = imem_req; imem_rvalid = imem_req;
      dmem_ack = dmem_req;
    end
    imem_gnt = 0; imem_rvalid = 0; dmem_ack = 0;
    check("rst_reached_mem", 64'(mem_seen), 64'd1);
`ifdef CORE_SEQ_RETIRE_CNT_EN
    check("rst_retired_before", retired_cnt, 1);
`endif
    arst_n = 0;
    @(negedge clk);
    arst_n = 1;
    clear_inputs();
    check("rst_mem_state", state_o, IDLE);
    check("rst_mem_outputs", {imem_req, dmem_req, dmem_we, pc_write_en, reg_write_en, busy, err}, 0);
    check("rst_mem_instr_q", instr_q, 0);
`ifdef CORE_SEQ_RETIRE_CNT_EN
    check("rst_mem_retired", retired_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
